// File: rtl/imem_fetch_ctrl.sv
// Fetch-stage controller for a synchronous-read instruction memory (1-cycle read latency).
// Owns the fetch PC, issues one read per cycle, and hands instructions to decode over a
// valid/ready handshake. A 1-entry skid buffer absorbs the read that is already in flight
// when decode stalls. Branch redirects flush every pending read.
module imem_fetch_ctrl #(
  parameter int unsigned       ADDR_W   = 3,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_run,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic [DATA_W-1:0] i_imem_dout,
  input  logic              i_redir_valid,
  input  logic [ADDR_W-1:0] i_redir_pc,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_instr,
  output logic [ADDR_W-1:0] o_out_pc,
  output logic [1:0]        o_st
);

  typedef enum logic [1:0] {
    StFill = 2'd0,  // out empty, read pending or idle
    StRun  = 2'd1,  // out valid, skid empty
    StHold = 2'd2   // skid valid
  } st_e;

  st_e               r_st, w_st_d;

  logic [ADDR_W-1:0] r_fpc, w_fpc_d;
  logic              r_inflight, w_inflight_d;
  logic [ADDR_W-1:0] r_inflight_pc, w_inflight_pc_d;

  logic              r_out_valid, w_out_valid_d;
  logic [DATA_W-1:0] r_out_instr, w_out_instr_d;
  logic [ADDR_W-1:0] r_out_pc, w_out_pc_d;

  logic              r_skid_valid, w_skid_valid_d;
  logic [DATA_W-1:0] r_skid_instr, w_skid_instr_d;
  logic [ADDR_W-1:0] r_skid_pc, w_skid_pc_d;

  logic              w_accept;
  logic              w_stall;
  logic              w_issue;

  assign w_accept = r_out_valid & i_out_ready;

  // Stop issuing whenever the next return could find both out and skid occupied. A full skid
  // that is draining this cycle does not stall, so a released back-pressure resumes at full rate
  // with no bubble: the new read returns just as the old skid entry leaves out.
  assign w_stall  = r_out_valid & ~i_out_ready & (r_skid_valid | r_inflight);
  assign w_issue  = i_run & ~i_redir_valid & ~w_stall;

  // Datapath next-state: fetch PC, in-flight tracking, out stage and skid buffer.
  always_comb begin
    w_fpc_d         = r_fpc;
    w_inflight_d    = 1'b0;
    w_inflight_pc_d = r_inflight_pc;
    w_out_valid_d   = r_out_valid;
    w_out_instr_d   = r_out_instr;
    w_out_pc_d      = r_out_pc;
    w_skid_valid_d  = r_skid_valid;
    w_skid_instr_d  = r_skid_instr;
    w_skid_pc_d     = r_skid_pc;

    if (i_redir_valid) begin
      // Flush everything; the data returning this cycle belongs to the abandoned path.
      w_fpc_d        = i_redir_pc;
      w_inflight_d   = 1'b0;
      w_out_valid_d  = 1'b0;
      w_skid_valid_d = 1'b0;
    end else begin
      if (w_issue) begin
        w_fpc_d         = r_fpc + ADDR_W'(1);
        w_inflight_d    = 1'b1;
        w_inflight_pc_d = r_fpc;
      end

      if (r_skid_valid) begin
        // A full skid implies nothing was in flight: the skid entry is older than any return.
        if (w_accept) begin
          w_out_valid_d  = 1'b1;
          w_out_instr_d  = r_skid_instr;
          w_out_pc_d     = r_skid_pc;
          w_skid_valid_d = 1'b0;
        end
      end else if (r_inflight) begin
        if (!r_out_valid || w_accept) begin
          w_out_valid_d = 1'b1;
          w_out_instr_d = i_imem_dout;
          w_out_pc_d    = r_inflight_pc;
        end else begin
          w_skid_valid_d = 1'b1;
          w_skid_instr_d = i_imem_dout;
          w_skid_pc_d    = r_inflight_pc;
        end
      end else if (w_accept) begin
        w_out_valid_d = 1'b0;
      end
    end
  end

  // Control FSM next-state; tracks occupancy of the out stage and skid buffer.
  always_comb begin
    w_st_d = r_st;
    if (i_redir_valid) begin
      w_st_d = StFill;
    end else begin
      unique case (r_st)
        StFill: begin
          if (r_inflight) w_st_d = StRun;
        end
        StRun: begin
          if (r_inflight && !w_accept)      w_st_d = StHold;
          else if (!r_inflight && w_accept) w_st_d = StFill;
          else                              w_st_d = StRun;
        end
        StHold: begin
          if (w_accept) w_st_d = StRun;
        end
        default: w_st_d = StFill;
      endcase
    end
  end

  // State registers with synchronous active-high reset; in-flight memory data is dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_st          <= StFill;
      r_fpc         <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_out_valid   <= 1'b0;
      r_out_instr   <= '0;
      r_out_pc      <= '0;
      r_skid_valid  <= 1'b0;
      r_skid_instr  <= '0;
      r_skid_pc     <= '0;
    end else begin
      r_st          <= w_st_d;
      r_fpc         <= w_fpc_d;
      r_inflight    <= w_inflight_d;
      r_inflight_pc <= w_inflight_pc_d;
      r_out_valid   <= w_out_valid_d;
      r_out_instr   <= w_out_instr_d;
      r_out_pc      <= w_out_pc_d;
      r_skid_valid  <= w_skid_valid_d;
      r_skid_instr  <= w_skid_instr_d;
      r_skid_pc     <= w_skid_pc_d;
    end
  end

  assign o_imem_addr = r_fpc;
  assign o_out_valid = r_out_valid;
  assign o_out_instr = r_out_instr;
  assign o_out_pc    = r_out_pc;
  assign o_st        = r_st;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a synchronous-read memory model and an
// expected-PC scoreboard popped on every decode handshake.
module tb_imem_fetch_ctrl;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic              clk = 1'b0;
  logic              rst;
  logic              run;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_dout;
  logic              redir_valid;
  logic [ADDR_W-1:0] redir_pc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic [1:0]        st;

  logic [DATA_W-1:0] mem [8];
  logic [ADDR_W-1:0] exp_q [$];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Synchronous-read memory: data for the address seen at an edge appears after that edge.
  always @(posedge clk) imem_dout <= mem[imem_addr];

  imem_fetch_ctrl #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .RESET_PC('0)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_run        (run),
    .o_imem_addr  (imem_addr),
    .i_imem_dout  (imem_dout),
    .i_redir_valid(redir_valid),
    .i_redir_pc   (redir_pc),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_out_instr  (out_instr),
    .o_out_pc     (out_pc),
    .o_st         (st)
  );

  function automatic logic [DATA_W-1:0] instr_of(input logic [ADDR_W-1:0] pc);
    return 32'hA000_0000 | 32'(pc);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Score the handshake of the current cycle, then advance to just after the next edge.
  task automatic tick();
    logic [ADDR_W-1:0] p;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_extra_delivery", 64'(out_pc), 64'hFF);
      end else begin
        p = exp_q.pop_front();
        chk("sb_pc", 64'(out_pc), 64'(p));
        chk("sb_instr", 64'(out_instr), 64'(instr_of(p)));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_range(input int first, input int count);
    for (int i = 0; i < count; i++) exp_q.push_back(ADDR_W'(first + i));
  endtask

  task automatic wait_out(input logic [ADDR_W-1:0] pc, input string tag);
    int n = 0;
    while (!(out_valid === 1'b1 && out_pc === pc) && n < 40) begin
      tick();
      n++;
    end
    chk(tag, 64'({out_valid, out_pc}), 64'({1'b1, pc}));
  endtask

  initial begin
    for (int k = 0; k < 8; k++) mem[k] = instr_of(ADDR_W'(k));
    rst = 1'b1; run = 1'b1; out_ready = 1'b1; redir_valid = 1'b0; redir_pc = '0;
    @(posedge clk); #1;
    tick();

    // Reset state
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_imem_addr", 64'(imem_addr), 64'd0);
    chk("rst_st", 64'(st), 64'(ST_FILL));
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'd0);

    // T1: streaming with wrap, 2-cycle latency, 1 instruction per cycle
    rst = 1'b0;
    push_range(0, 10);
    chk("t1_c0_addr", 64'(imem_addr), 64'd0);
    tick();
    chk("t1_c1_valid", 64'(out_valid), 64'd0);
    chk("t1_c1_addr", 64'(imem_addr), 64'd1);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("t1_stream_valid", 64'(out_valid), 64'd1);
      tick();
    end

    // T2: back-pressure for 5 cycles with pc2 in out
    chk("t2_start_pc", 64'(out_pc), 64'd2);
    chk("t2_start_st", 64'(st), 64'(ST_RUN));
    out_ready = 1'b0;
    push_range(2, 3);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_hold_valid", 64'(out_valid), 64'd1);
      chk("t2_hold_pc", 64'(out_pc), 64'd2);
      chk("t2_hold_instr", 64'(out_instr), 64'(instr_of(3'd2)));
      chk("t2_hold_addr", 64'(imem_addr), 64'd4);
      chk("t2_hold_st", 64'(st), 64'(ST_HOLD));
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t2_release_valid", 64'(out_valid), 64'd1);
      tick();
    end

    // T3: redirect to 6 while pc1 is in out and pc2 is in flight
    push_range(5, 5);
    wait_out(3'd1, "t3_reach_pc1");
    chk("t3_pc2_issued", 64'(imem_addr), 64'd3);
    redir_valid = 1'b1; redir_pc = 3'd6;
    tick();
    redir_valid = 1'b0;
    chk("t3_flush_valid", 64'(out_valid), 64'd0);
    chk("t3_flush_st", 64'(st), 64'(ST_FILL));
    chk("t3_flush_addr", 64'(imem_addr), 64'd6);
    push_range(6, 2);
    tick();
    chk("t3_gap_valid", 64'(out_valid), 64'd0);
    tick();
    chk("t3_target_valid", 64'(out_valid), 64'd1);
    chk("t3_target_pc", 64'(out_pc), 64'd6);
    tick();
    tick();

    // T4: redirect while HOLD with decode stalled; pc0 and pc1 must vanish
    chk("t4_pc0_out", 64'(out_pc), 64'd0);
    out_ready = 1'b0;
    tick();
    chk("t4_hold_st", 64'(st), 64'(ST_HOLD));
    redir_valid = 1'b1; redir_pc = 3'd3;
    tick();
    redir_valid = 1'b0;
    out_ready = 1'b1;
    chk("t4_flush_valid", 64'(out_valid), 64'd0);
    chk("t4_flush_st", 64'(st), 64'(ST_FILL));
    chk("t4_flush_addr", 64'(imem_addr), 64'd3);
    push_range(3, 2);
    tick();
    chk("t4_gap_valid", 64'(out_valid), 64'd0);
    tick();
    chk("t4_target_valid", 64'(out_valid), 64'd1);
    chk("t4_target_pc", 64'(out_pc), 64'd3);

    // T5: run=0 mid-stream; the outstanding read still lands, the address does not advance
    run = 1'b0;
    tick();
    chk("t5_inflight_valid", 64'(out_valid), 64'd1);
    chk("t5_inflight_pc", 64'(out_pc), 64'd4);
    chk("t5_addr_frozen_a", 64'(imem_addr), 64'd5);
    tick();
    chk("t5_drained_valid", 64'(out_valid), 64'd0);
    chk("t5_drained_st", 64'(st), 64'(ST_FILL));
    chk("t5_addr_frozen_b", 64'(imem_addr), 64'd5);
    tick();
    chk("t5_idle_valid", 64'(out_valid), 64'd0);
    chk("t5_addr_frozen_c", 64'(imem_addr), 64'd5);
    run = 1'b1;
    push_range(5, 2);
    tick();
    chk("t5_resume_addr", 64'(imem_addr), 64'd6);
    chk("t5_resume_gap", 64'(out_valid), 64'd0);
    tick();
    chk("t5_resume_valid", 64'(out_valid), 64'd1);
    chk("t5_resume_pc", 64'(out_pc), 64'd5);
    tick();
    tick();

    // T6: reset pulse while HOLD
    chk("t6_pc7_out", 64'(out_pc), 64'd7);
    out_ready = 1'b0;
    tick();
    chk("t6_hold_st", 64'(st), 64'(ST_HOLD));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    chk("t6_rst_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_st", 64'(st), 64'(ST_FILL));
    chk("t6_rst_addr", 64'(imem_addr), 64'd0);
    exp_q.delete();
    push_range(0, 3);
    tick();
    chk("t6_gap_valid", 64'(out_valid), 64'd0);
    tick();
    chk("t6_restart_valid", 64'(out_valid), 64'd1);
    chk("t6_restart_pc", 64'(out_pc), 64'd0);
    for (int n = 0; n < 20 && exp_q.size() > 0; n++) tick();
    out_ready = 1'b0;
    chk("sb_all_delivered", 64'(exp_q.size()), 64'd0);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
